// File: rtl/alu_pkg.sv
// Shared constants for the ALU_8bits datapath: divider FSM encodings and result defaults.
package alu_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;
  localparam logic [1:0] StFix  = 2'd3;

  localparam logic [7:0] DIV_ZERO_Q = 8'hFF;

endpackage

// File: rtl/div_8bits_seq_if.sv
// Start/done handshake and operand/result bundle between the ALU controller and the divider.
interface div_8bits_seq_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             div_zero;

  modport master (output start, a, b, input busy, done, q, r, div_zero);
  modport slave  (input start, a, b, output busy, done, q, r, div_zero);

endinterface

// File: rtl/div_8bits_seq_div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract.
module div_step
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH:0]   p,
  input  logic             dbit,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   p_next,
  output logic             qbit
);

  logic [WIDTH:0] t;
  // The partial remainder stays below b, so its top bit never carries information.
  logic           unused_p_msb;

  assign unused_p_msb = p[WIDTH];
  assign t            = {p[WIDTH-1:0], dbit};

  always_comb begin
    if (t >= {1'b0, b}) begin
      p_next = t - {1'b0, b};
      qbit   = 1'b1;
    end else begin
      p_next = t;
      qbit   = 1'b0;
    end
  end

endmodule

// File: rtl/div_8bits_seq.sv
// Sequential restoring divider, one quotient bit per clock, start/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands (adds a sign-fix state, +1 cycle latency).
module div_8bits_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = 3
) (
  input logic            clk,
  input logic            rst,
  div_8bits_seq_if.slave bus
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
`ifdef DIV_SIGNED_EN
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
`endif

  logic [WIDTH:0] step_p;
  logic           step_qbit;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .p      (p_q),
    .dbit   (dvd_q[cnt_q]),
    .b      (dvs_q),
    .p_next (step_p),
    .qbit   (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
`ifdef DIV_SIGNED_EN
    neg_d   = neg_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.start) begin
          dz_d = 1'b0;
          if (bus.b == '0) begin
            q_d     = WIDTH'(DIV_ZERO_Q);
            r_d     = bus.a;
            dz_d    = 1'b1;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
`ifdef DIV_SIGNED_EN
            // Divide magnitudes; the signs are reapplied in StFix.
            dvd_d  = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
            dvs_d  = bus.b[WIDTH-1] ? (~bus.b + 1'b1) : bus.b;
            neg_d  = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            rneg_d = bus.a[WIDTH-1];
`else
            dvd_d  = bus.a;
            dvs_d  = bus.b;
`endif
            p_d     = '0;
            cnt_d   = CNT_W'(WIDTH - 1);
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        p_d   = step_p;
        quo_d = {quo_q[WIDTH-2:0], step_qbit};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
`ifdef DIV_SIGNED_EN
          state_d = StFix;
`else
          q_d     = quo_d;
          r_d     = step_p[WIDTH-1:0];
          done_d  = 1'b1;
          state_d = StDone;
`endif
        end
      end
`ifdef DIV_SIGNED_EN
      StFix: begin
        q_d     = neg_q ? (~quo_q + 1'b1) : quo_q;
        r_d     = rneg_q ? (~p_q[WIDTH-1:0] + 1'b1) : p_q[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = StDone;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      p_q     <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      q_q     <= q_d;
      r_q     <= r_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
`ifdef DIV_SIGNED_EN
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign bus.busy     = (state_q == StCalc) || (state_q == StFix);
  assign bus.done     = done_q;
  assign bus.q        = q_q;
  assign bus.r        = r_q;
  assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_div_8bits_seq.sv
// Self-checking bench for div_8bits_seq: arithmetic reference model plus directed vectors.
module tb_div_8bits_seq;

`ifdef DIV_SIGNED_EN
  localparam int         LAT    = 9;
  localparam bit         SIGNED = 1'b1;
  localparam logic [15:0] R200_7 = 16'hF800;  // -56 / 7
  localparam logic [15:0] R150_4 = 16'hE6FE;  // -106 / 4
`else
  localparam int         LAT    = 8;
  localparam bit         SIGNED = 1'b0;
  localparam logic [15:0] R200_7 = 16'h1C04;
  localparam logic [15:0] R150_4 = 16'h2502;
`endif

  logic clk = 1'b0;
  logic rst;
  logic chk_en = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  div_8bits_seq_if #(.WIDTH(8)) bus ();

  div_8bits_seq #(
    .WIDTH (8),
    .CNT_W (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Returns {quotient, remainder} straight from integer arithmetic.
  function automatic logic [15:0] ref_div(input logic [7:0] x, input logic [7:0] y);
    int sx, sy;
    if (SIGNED) begin
      if (x == 8'h80 && y == 8'hFF) return 16'h8000;
      sx = int'($signed(x));
      sy = int'($signed(y));
      return {8'(sx / sy), 8'(sx % sy)};
    end
    return {x / y, x % y};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: remaining busy cycles plus the result it will publish.
  logic [7:0]  m_q = '0, m_r = '0;
  logic        m_dz = 1'b0, m_done = 1'b0;
  logic [15:0] m_pend = '0;
  int          m_left = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_q <= '0; m_r <= '0; m_dz <= 1'b0; m_done <= 1'b0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_q    <= m_pend[15:8];
          m_r    <= m_pend[7:0];
        end
      end else if (bus.start) begin
        m_dz <= (bus.b == 8'd0);
        if (bus.b == 8'd0) begin
          m_done <= 1'b1;
          m_q    <= 8'hFF;
          m_r    <= bus.a;
        end else begin
          m_pend <= ref_div(bus.a, bus.b);
          m_left <= LAT;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_done", bus.done, m_done);
      chk("cyc_busy", bus.busy, m_left > 0);
      chk("cyc_q", bus.q, m_q);
      chk("cyc_r", bus.r, m_r);
      chk("cyc_dz", bus.div_zero, m_dz);
    end
  end

  task automatic start_op(input logic [7:0] x, input logic [7:0] y);
    bus.start = 1'b1;
    bus.a     = x;
    bus.b     = y;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 8'hA5;
    bus.b     = 8'h5A;
  endtask

  // Counts clock edges between the start edge and the done edge.
  task automatic wait_done(input string name, input int exp_lat);
    int lat = 0;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_lat"}, lat, exp_lat);
  endtask

  initial begin
    int pulses;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_out", {bus.busy, bus.done, bus.div_zero, bus.q, bus.r}, '0);
    rst = 1'b0;
    @(negedge clk);

    chk("model_100_9", ref_div(8'd100, 8'd9), 16'h0B01);
    chk("model_9_3", ref_div(8'd9, 8'd3), 16'h0300);

    start_op(8'd200, 8'd7);
    wait_done("t200_7", LAT);
    chk("t200_7_qr", {bus.q, bus.r}, R200_7);
    chk("t200_7_dz", bus.div_zero, 1'b0);

    @(negedge clk);
    start_op(8'd5, 8'd0);
    wait_done("dz", 0);
    chk("dz_qr", {bus.q, bus.r}, 16'hFF05);
    chk("dz_flag", {bus.div_zero, bus.busy}, 2'b10);

    @(negedge clk);
    start_op(8'd255, 8'd1);
    wait_done("b2b_a", LAT);
    chk("b2b_a_qr", {bus.q, bus.r}, 16'hFF00);
    start_op(8'd9, 8'd3);
    wait_done("b2b_b", LAT);
    chk("b2b_b_qr", {bus.q, bus.r}, 16'h0300);

    @(negedge clk);
    start_op(8'd100, 8'd9);
    repeat (2) @(negedge clk);
    start_op(8'd1, 8'd1);
    wait_done("ignore", LAT - 3);
    chk("ignore_qr", {bus.q, bus.r}, 16'h0B01);

    @(negedge clk);
    start_op(8'd150, 8'd4);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out", {bus.busy, bus.done, bus.div_zero, bus.q, bus.r}, '0);
    rst    = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    chk("midrst_nodone", pulses, 0);
    start_op(8'd150, 8'd4);
    wait_done("t150_4", LAT);
    chk("t150_4_qr", {bus.q, bus.r}, R150_4);

`ifdef DIV_SIGNED_EN
    @(negedge clk);
    start_op(8'h9C, 8'h07);
    wait_done("sneg", LAT);
    chk("sneg_qr", {bus.q, bus.r}, 16'hF2FE);
    @(negedge clk);
    start_op(8'h80, 8'hFF);
    wait_done("sovf", LAT);
    chk("sovf_qr", {bus.q, bus.r}, 16'h8000);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
